load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator-side load/store sequencer between the pipeline's memory stage and the word-organised data memory with byte-lane write enables.
- Accepts one RV32 load/store request per handshake and drives word-aligned memory accesses with byte enables.
- Splits misaligned accesses that cross a word boundary into two word accesses.
- Reassembles, sign- or zero-extends load data and returns a single registered response.

Parameters:
DM_ADDRESS, 9, byte-address width of the data memory; upper request address bits are ignored.
DATA_W, 32, data width; fixed at 32.

Ports:
clk  input  1  clock; all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  instruction bits 14:12
req_addr  input  DATA_W  byte address; only bits DM_ADDRESS-1:0 are used
req_wdata  input  DATA_W  store data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  DATA_W  load result; 0 for stores and errors
resp_err  output  1  illegal funct3 or out-of-range access, qualified by resp_valid
mem_addr  output  DM_ADDRESS  word-aligned byte address; bits 1:0 are always 0
mem_rd  output  1  read strobe
mem_wr  output  4  byte-lane write enables; bit i = bits 8i+7:8i
mem_wdata  output  DATA_W  lane-positioned write data
mem_rdata  input  DATA_W  read data, valid the cycle after mem_rd

Behaviour:
- Reset:
  - Async and active-low.
  - FSM goes to IDLE; all registers clear.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - req_ready=1 after release.
  - Reset during a split store can leave word0 written and word1 unwritten. This is accepted behaviour.
- Size and offset:
  - off = addr[1:0].
  - Size: funct3 000/100 = 1 byte, 001/101 = 2 bytes, 010 = 4 bytes.
  - Loads legal funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores legal funct3: 000 SB, 001 SH, 010 SW.
  - split = (off + size > 4).
  - w0 = {addr[DM_ADDRESS-1:2], 2'b00}; w1 = w0 + 4.
- Error at accept:
  - Conditions: illegal funct3, or split with w0 at the top word (w1 overflows DM_ADDRESS bits).
  - Response: resp_valid=1, resp_err=1 on T+1; FSM stays IDLE; no memory strobe.
- Store data path:
  - 8-bit mask = ((1<<size)-1) << off.
  - 64-bit data = req_wdata << (8*off).
  - Low half goes to word0 (mask[3:0]); high half goes to word1 (mask[7:4]).
- Load data path:
  - {word1, word0} >> (8*off), truncated to size.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - word1 = 0 when not split.
- FSM:
  - IDLE: req_ready=1. On req_valid with a legal request, latch request, compute masks → ACC0.
  - ACC0: mem_addr=w0. Load: mem_rd=1. Store: mem_wr=mask[3:0], mem_wdata=low half. Next state: split → ACC1, else CAP.
  - ACC1: mem_addr=w1. Load: mem_rd=1. Store: mem_wr=mask[7:4], mem_wdata=high half. Load also captures mem_rdata into buf0 (ACC0 data). → CAP.
  - CAP: no strobes. Load captures mem_rdata into buf1 if split, else into buf0. → RESP.
  - RESP: registers are loaded so that resp_valid=1 and resp_rdata is assembled on the next edge. → IDLE.
- Response timing:
  - resp_valid asserts the cycle the FSM re-enters IDLE.
  - A new request can be accepted in that same cycle.
- Latency (accept edge = T, resp_valid high):
  - Aligned: T+4.
  - Split: T+5.
  - Error: T+1.
- Outputs:
  - mem_rd and mem_wr are high only in ACC0/ACC1; combinational from state plus registered fields.
  - All resp_* outputs are registered.
  - No response backpressure; resp_valid is a single-cycle pulse.
- req_valid while busy is ignored (req_ready=0); the requester must hold it.

Test Plan:
- LW addr 0x010, mem[0x010]=0x11223344 → one mem_rd at addr 0x010; resp_rdata=0x11223344, resp_err=0 at T+4.
- LW addr 0x013, mem[0x010]=0xAABBCCDD, mem[0x014]=0x11223344 → mem_rd at 0x010 then 0x014 on consecutive cycles; resp_rdata=0x223344AA at T+5.
- SH addr 0x003, wdata 0x0000BEEF → cycle 1: addr 0x000, mem_wr=1000, mem_wdata[31:24]=0xEF; cycle 2: addr 0x004, mem_wr=0001, mem_wdata[7:0]=0xBE; resp_valid at T+5.
- mem[0x000]=0x0080FF00: LB addr 0x002 → 0xFFFFFF80; LBU addr 0x002 → 0x00000080; LHU addr 0x001 → 0x000080FF.
- SW addr 0x1FE (DM_ADDRESS=9) → resp_err=1 at T+1, mem_wr stays 0000. Load funct3=011 → resp_err=1, mem_rd never asserted.
- reset_n low during ACC1 of a split store → mem_wr=0 and resp_valid=0 immediately; after release, req_ready=1 and no response is ever issued for the aborted request.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store sequencer to byte-lane word memory; splits word-crossing accesses, returns one registered response
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_rd,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;
  state_t state, nxt;
  logic we, split;
  logic [2:0] f3;
  logic [1:0] off;
  logic [DM_ADDRESS-1:0] w0;
  logic [7:0] mask;
  logic [2*DATA_W-1:0] wd;
  logic [DATA_W-1:0] buf0, buf1, ld;
  logic [2*DATA_W-1:0] sh;
  logic [1:0] roff;
  logic [2:0] rsize;
  logic rsplit, legal, bad;
  logic [7:0] rmask;
  logic [2*DATA_W-1:0] rwd;
  logic unused_hi;
  assign unused_hi = ^req_addr[DATA_W-1:DM_ADDRESS];
  assign roff = req_addr[1:0];
  assign rsize = req_funct3[1] ? 3'd4 : req_funct3[0] ? 3'd2 : 3'd1;
  assign rsplit = ({1'b0, roff} + rsize) > 3'd4;
  assign legal = req_funct3[1:0] != 2'b11 && !(req_funct3[2] && (req_we || req_funct3[1]));
  assign bad = !legal || (rsplit && &req_addr[DM_ADDRESS-1:2]);
  assign rmask = ((8'd1 << rsize) - 8'd1) << roff;
  assign rwd = {{DATA_W{1'b0}}, req_wdata} << {roff, 3'b000};
  assign sh = {buf1, buf0} >> {off, 3'b000};
  assign ld = f3[1] ? sh[DATA_W-1:0] :
              f3[0] ? {{16{~f3[2] & sh[15]}}, sh[15:0]} :
                      {{24{~f3[2] & sh[7]}}, sh[7:0]};
  always_comb begin
    nxt = state;
    req_ready = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 4'b0000;
    mem_addr = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        nxt = (req_valid && !bad) ? ACC0 : IDLE;
      end
      ACC0: begin
        mem_addr = w0;
        mem_rd = !we;
        mem_wr = we ? mask[3:0] : 4'b0000;
        mem_wdata = we ? wd[DATA_W-1:0] : '0;
        nxt = split ? ACC1 : CAP;
      end
      ACC1: begin
        mem_addr = w0 + DM_ADDRESS'(4);
        mem_rd = !we;
        mem_wr = we ? mask[7:4] : 4'b0000;
        mem_wdata = we ? wd[2*DATA_W-1:DATA_W] : '0;
        nxt = CAP;
      end
      CAP: nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      we <= 1'b0;
      split <= 1'b0;
      f3 <= '0;
      off <= '0;
      w0 <= '0;
      mask <= '0;
      wd <= '0;
      buf0 <= '0;
      buf1 <= '0;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= nxt;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
      if (state == IDLE && req_valid) begin
        if (bad) begin
          resp_valid <= 1'b1;
          resp_err <= 1'b1;
        end else begin
          we <= req_we;
          f3 <= req_funct3;
          off <= roff;
          split <= rsplit;
          w0 <= {req_addr[DM_ADDRESS-1:2], 2'b00};
          mask <= rmask;
          wd <= rwd;
          buf1 <= '0;
        end
      end
      if (state == ACC1 && !we) buf0 <= mem_rdata;
      if (state == CAP && !we) begin
        if (split) buf1 <= mem_rdata;
        else buf0 <= mem_rdata;
      end
      if (state == RESP) begin
        resp_valid <= 1'b1;
        resp_rdata <= we ? '0 : ld;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_rd;
  logic [31:0] resp_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [8:0] mem_addr;
  logic [3:0] mem_wr;
  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [128];
  logic [7:0] refm [512];
  int checks = 0, errors = 0, cyc = 0;
  int exp_due = -1, n_rd = 0, n_wr = 0, n_log = 0;
  logic [31:0] exp_rdata = '0, last_rdata = '0;
  logic exp_err = 1'b0, last_err = 1'b0, done = 1'b0;
  logic [8:0] lg_addr [4];
  logic [3:0] lg_wr [4];
  logic [31:0] lg_wd [4];
  logic lg_rd [4];
  function automatic void chk(string n, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, want);
    end
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr[8:2]];
    for (int i = 0; i < 4; i++)
      if (mem_wr[i]) mem[mem_addr[8:2]][8*i+:8] <= mem_wdata[8*i+:8];
  end
  always @(negedge clk) begin
    if (reset_n) begin
      chk("resp_valid", resp_valid, exp_due == cyc);
      if (exp_due == cyc) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", resp_err, exp_err);
        last_rdata = resp_rdata;
        last_err = resp_err;
        exp_due = -1;
        done = 1'b1;
      end
      if (mem_rd || mem_wr != 0) begin
        chk("mem_addr_aligned", mem_addr[1:0], 0);
        n_rd += mem_rd ? 1 : 0;
        n_wr += (mem_wr != 0) ? 1 : 0;
        if (n_log < 4) begin
          lg_addr[n_log] = mem_addr;
          lg_wr[n_log] = mem_wr;
          lg_wd[n_log] = mem_wdata;
          lg_rd[n_log] = mem_rd;
        end
        n_log++;
      end
    end
  end
  function automatic int size_of(logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction
  function automatic logic [31:0] mload(logic [2:0] f3, int a);
    int sz = size_of(f3);
    logic [31:0] v = '0;
    for (int i = 0; i < sz; i++) v[8*i+:8] = refm[(a + i) % 512];
    if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction
  task automatic setw(input int a, input logic [31:0] v);
    mem[a / 4] = v;
    for (int i = 0; i < 4; i++) refm[(a & ~3) + i] = v[8*i+:8];
  endtask
  task automatic mcheck(input string n);
    int bad = 0;
    for (int w = 0; w < 128; w++)
      if (mem[w] !== {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]}) bad++;
    chk(n, bad, 0);
  endtask
  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int a, sz, ex_rd, ex_wr;
    logic er, sp;
    a = int'(addr[8:0]);
    sz = size_of(f3);
    er = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    er = er || (a + sz > 512);
    sp = (a % 4) + sz > 4;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    exp_rdata = (er || we) ? 32'h0 : mload(f3, a);
    exp_err = er;
    done = 1'b0;
    n_rd = 0;
    n_wr = 0;
    n_log = 0;
    exp_due = cyc + (er ? 0 : (sp ? 4 : 3));
    if (we && !er) for (int i = 0; i < sz; i++) refm[(a + i) % 512] = wd[8*i+:8];
    ex_rd = (!we && !er) ? (sp ? 2 : 1) : 0;
    ex_wr = (we && !er) ? (sp ? 2 : 1) : 0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int w = 0; w < 20 && !done; w++) @(posedge clk);
    if (!done) begin
      chk("resp_timeout", done, 1);
      exp_due = -1;
    end
    @(negedge clk);
    #1;
    chk("n_rd", n_rd, ex_rd);
    chk("n_wr", n_wr, ex_wr);
  endtask
  initial begin
    for (int w = 0; w < 128; w++) setw(4 * w, 32'h0);
    #2;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1);
    setw(32'h010, 32'h11223344);
    req(1'b0, 3'b010, 32'h010, 32'h0);
    chk("lw_al_data", last_rdata, 32'h11223344);
    chk("lw_al_log", {lg_rd[0], 7'd0, lg_addr[0]}, {1'b1, 7'd0, 9'h010});
    setw(32'h010, 32'hAABBCCDD);
    setw(32'h014, 32'h11223344);
    req(1'b0, 3'b010, 32'h013, 32'h0);
    chk("lw_split_data", last_rdata, 32'h223344AA);
    chk("lw_split_a0", lg_addr[0], 9'h010);
    chk("lw_split_a1", lg_addr[1], 9'h014);
    setw(32'h000, 32'h0);
    setw(32'h004, 32'h0);
    req(1'b1, 3'b001, 32'h003, 32'h0000BEEF);
    chk("sh_a0", lg_addr[0], 9'h000);
    chk("sh_wr0", lg_wr[0], 4'b1000);
    chk("sh_wd0", lg_wd[0][31:24], 8'hEF);
    chk("sh_a1", lg_addr[1], 9'h004);
    chk("sh_wr1", lg_wr[1], 4'b0001);
    chk("sh_wd1", lg_wd[1][7:0], 8'hBE);
    mcheck("sh_mem");
    setw(32'h000, 32'h0080FF00);
    req(1'b0, 3'b000, 32'h002, 32'h0);
    chk("lb_data", last_rdata, 32'hFFFFFF80);
    req(1'b0, 3'b100, 32'h002, 32'h0);
    chk("lbu_data", last_rdata, 32'h00000080);
    req(1'b0, 3'b101, 32'h001, 32'h0);
    chk("lhu_data", last_rdata, 32'h000080FF);
    req(1'b0, 3'b001, 32'h001, 32'h0);
    chk("lh_data", last_rdata, 32'hFFFF80FF);
    req(1'b1, 3'b010, 32'h1FE, 32'h12345678);
    chk("sw_oob_err", last_err, 1);
    chk("sw_oob_nlog", n_log, 0);
    req(1'b0, 3'b011, 32'h020, 32'h0);
    chk("ld_f3_err", last_err, 1);
    req(1'b1, 3'b100, 32'h020, 32'h0);
    chk("st_f3_err", last_err, 1);
    req(1'b0, 3'b101, 32'h1FF, 32'h0);
    chk("lhu_oob_err", last_err, 1);
    setw(32'h1FC, 32'hDEADBEEF);
    req(1'b0, 3'b010, 32'h1FC, 32'h0);
    chk("lw_top_data", last_rdata, 32'hDEADBEEF);
    req(1'b1, 3'b000, 32'hFFFF_F021, 32'h000000A5);
    req(1'b1, 3'b010, 32'h024, 32'h87654321);
    req(1'b1, 3'b001, 32'h0FF, 32'h0000C3D2);
    mcheck("store_mem");
    req(1'b0, 3'b001, 32'h0FF, 32'h0);
    chk("lh_split_data", last_rdata, 32'hFFFFC3D2);
    req(1'b0, 3'b010, 32'h022, 32'h0);
    req(1'b0, 3'b000, 32'h021, 32'h0);
    chk("lb_upper_ign", last_rdata, 32'hFFFFFFA5);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h0FE;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    exp_due = -1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_acc1_wr", mem_wr, 4'b0011);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_wr", mem_wr, 0);
    chk("abort_resp_valid", resp_valid, 0);
    refm[32'h0FE] = 8'h0D;
    refm[32'h0FF] = 8'hF0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("abort_req_ready", req_ready, 1);
    repeat (10) @(negedge clk);
    #1;
    mcheck("abort_mem");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
